// File: rtl/calc_pkg.sv
// Shared key codes, operation and FSM state types for the hex calculator controller.
package calc_pkg;

  localparam logic [4:0] KEY_EQ   = 5'd16;
  localparam logic [4:0] KEY_BKSP = 5'd17;
  localparam logic [4:0] KEY_SUB  = 5'd18;
  localparam logic [4:0] KEY_ADD  = 5'd19;
  localparam logic [4:0] KEY_MUL  = 5'd20;
  localparam logic [4:0] KEY_CLR  = 5'd21;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_ADD  = 2'd1,
    OP_SUB  = 2'd2,
    OP_MUL  = 2'd3
  } op_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  function automatic logic is_op_key(input logic [4:0] k);
    return (k == KEY_ADD) || (k == KEY_SUB) || (k == KEY_MUL);
  endfunction

  function automatic op_t key_to_op(input logic [4:0] k);
    op_t o;
    case (k)
      KEY_ADD: o = OP_ADD;
      KEY_SUB: o = OP_SUB;
      KEY_MUL: o = OP_MUL;
      default: o = OP_NONE;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/mul_shiftadd.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, WIDTH cycles per product.
// The start edge already folds in bit 0; done is high for the cycle after the last bit.
module mul_shiftadd #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic             hi_nz
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               active_q, active_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    done     = active_q && (cnt_q == CW'(WIDTH));
    if (start) begin
      acc_d    = b[0] ? {{WIDTH{1'b0}}, a} : '0;
      mcand_d  = {{(WIDTH-1){1'b0}}, a, 1'b0};
      mplier_d = b >> 1;
      cnt_d    = CW'(1);
      active_d = 1'b1;
    end else if (done) begin
      active_d = 1'b0;
    end else if (active_q) begin
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
    end
  end

  assign product = acc_q[WIDTH-1:0];
  assign hi_nz   = |acc_q[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/calc_ctrl.sv
// Key-driven sequencing controller: key decode, entry/saved/op registers and IDLE/MUL FSM.
// Handshake: a key is taken on a rising edge when key_valid && key_ready; key_ready depends on state only.
module calc_ctrl
  import calc_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             key_valid,
  input  logic [4:0]       key,
  output logic             key_ready,
  output logic             key_drop,
  output logic [WIDTH-1:0] entry,
  output logic [WIDTH-1:0] saved,
  output logic             displaysaved,
  output logic             busy,
  output logic             overflow
);

  state_t           state_q, state_d;
  op_t              op_q, op_d;
  logic [WIDTH-1:0] entry_q, entry_d;
  logic [WIDTH-1:0] saved_q, saved_d;
  logic             ds_q, ds_d;
  logic             eq_q, eq_d;
  logic             ovf_q, ovf_d;
  logic             key_drop_q, key_drop_d;
  logic [4:0]       pend_q, pend_d;

  logic             mul_start, mul_done, mul_hi_nz;
  logic [WIDTH-1:0] mul_prod;

  logic [WIDTH:0]   sum_w, diff_w;
  logic [WIDTH-1:0] apply_res;
  logic             apply_ovf;
  logic             needs_apply;

  logic             commit_en, commit_apply, commit_ovf;
  logic [4:0]       commit_key;
  logic [WIDTH-1:0] commit_val;

  mul_shiftadd #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .a       (saved_q),
    .b       (entry_q),
    .done    (mul_done),
    .product (mul_prod),
    .hi_nz   (mul_hi_nz)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_NONE;
      entry_q    <= '0;
      saved_q    <= '0;
      ds_q       <= 1'b0;
      eq_q       <= 1'b0;
      ovf_q      <= 1'b0;
      key_drop_q <= 1'b0;
      pend_q     <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      entry_q    <= entry_d;
      saved_q    <= saved_d;
      ds_q       <= ds_d;
      eq_q       <= eq_d;
      ovf_q      <= ovf_d;
      key_drop_q <= key_drop_d;
      pend_q     <= pend_d;
    end
  end

  // Single-cycle apply() for NONE/ADD/SUB; MUL results come from the multiplier.
  always_comb begin
    sum_w     = {1'b0, saved_q} + {1'b0, entry_q};
    diff_w    = {1'b0, saved_q} - {1'b0, entry_q};
    apply_res = entry_q;
    apply_ovf = 1'b0;
    case (op_q)
      OP_ADD: begin
        apply_res = sum_w[WIDTH-1:0];
        apply_ovf = sum_w[WIDTH];
      end
      OP_SUB: begin
        apply_res = diff_w[WIDTH-1:0];
        apply_ovf = diff_w[WIDTH];
      end
      default: ;
    endcase
  end

  assign needs_apply = (key == KEY_EQ) || (is_op_key(key) && !eq_q);

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    entry_d      = entry_q;
    saved_d      = saved_q;
    ds_d         = ds_q;
    eq_d         = eq_q;
    ovf_d        = ovf_q;
    pend_d       = pend_q;
    key_drop_d   = key_valid && (state_q != ST_IDLE);
    mul_start    = 1'b0;
    commit_en    = 1'b0;
    commit_apply = 1'b0;
    commit_ovf   = 1'b0;
    commit_key   = key;
    commit_val   = apply_res;

    case (state_q)
      ST_IDLE: begin
        if (key_valid) begin
          if (!key[4]) begin
            if (eq_q) begin
              entry_d = {{(WIDTH-4){1'b0}}, key[3:0]};
              saved_d = '0;
              op_d    = OP_NONE;
              ds_d    = 1'b0;
              eq_d    = 1'b0;
              ovf_d   = 1'b0;
            end else begin
              if (entry_q[WIDTH-1 -: 4] == 4'h0) entry_d = {entry_q[WIDTH-5:0], key[3:0]};
              ds_d = 1'b0;
            end
          end else if (key == KEY_BKSP) begin
            if (!ds_q) entry_d = entry_q >> 4;
          end else if (key == KEY_CLR) begin
            op_d    = OP_NONE;
            entry_d = '0;
            saved_d = '0;
            ds_d    = 1'b0;
            eq_d    = 1'b0;
            ovf_d   = 1'b0;
          end else if (key == KEY_EQ || is_op_key(key)) begin
            if (needs_apply && op_q == OP_MUL) begin
              // Defer the whole commit until the product is ready.
              mul_start = 1'b1;
              pend_d    = key;
              state_d   = ST_MUL;
            end else begin
              commit_en    = 1'b1;
              commit_apply = needs_apply;
              commit_ovf   = apply_ovf;
            end
          end
        end
      end
      ST_MUL: begin
        if (mul_done) begin
          commit_en    = 1'b1;
          commit_apply = 1'b1;
          commit_key   = pend_q;
          commit_val   = mul_prod;
          commit_ovf   = mul_hi_nz;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (commit_en) begin
      if (commit_apply) begin
        saved_d = commit_val;
        ovf_d   = ovf_q | commit_ovf;
      end
      ds_d = 1'b1;
      if (commit_key == KEY_EQ) begin
        eq_d = 1'b1;
      end else begin
        op_d    = key_to_op(commit_key);
        entry_d = '0;
        eq_d    = 1'b0;
      end
    end
  end

  assign key_ready    = (state_q == ST_IDLE);
  assign busy         = (state_q == ST_MUL);
  assign key_drop     = key_drop_q;
  assign entry        = entry_q;
  assign saved        = saved_q;
  assign displaysaved = ds_q;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_calc_ctrl.sv
// Self-checking bench for calc_ctrl against an arithmetic reference model of the calculator.
module tb_calc_ctrl;

  localparam int W = 32;
  localparam logic [4:0] K_EQ   = 5'd16;
  localparam logic [4:0] K_BKSP = 5'd17;
  localparam logic [4:0] K_SUB  = 5'd18;
  localparam logic [4:0] K_ADD  = 5'd19;
  localparam logic [4:0] K_MUL  = 5'd20;
  localparam logic [4:0] K_CLR  = 5'd21;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         key_valid = 1'b0;
  logic [4:0]   key = '0;
  logic         key_ready, key_drop, displaysaved, busy, overflow;
  logic [W-1:0] entry, saved;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [W-1:0] m_entry, m_saved;
  int           m_op;
  logic         m_eq, m_ds, m_ovf;

  calc_ctrl #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .key_valid    (key_valid),
    .key          (key),
    .key_ready    (key_ready),
    .key_drop     (key_drop),
    .entry        (entry),
    .saved        (saved),
    .displaysaved (displaysaved),
    .busy         (busy),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  task automatic model_clear();
    m_entry = '0; m_saved = '0; m_op = 0; m_eq = 0; m_ds = 0; m_ovf = 0;
  endtask

  task automatic model_key(input logic [4:0] k, output bit is_mul);
    logic [63:0] full;
    bit need;
    is_mul = 0;
    need = (k == K_EQ) || ((k == K_ADD || k == K_SUB || k == K_MUL) && !m_eq);
    if (k < 16) begin
      if (m_eq) begin
        m_entry = W'(k); m_saved = '0; m_op = 0; m_ds = 0; m_eq = 0; m_ovf = 0;
      end else begin
        if (m_entry < 32'h1000_0000) m_entry = m_entry * 16 + W'(k);
        m_ds = 0;
      end
    end else if (k == K_BKSP) begin
      if (!m_ds) m_entry = m_entry / 16;
    end else if (k == K_CLR) begin
      model_clear();
    end else if (k >= K_EQ && k <= K_MUL) begin
      if (need) begin
        case (m_op)
          1: begin
            full = {32'b0, m_saved} + {32'b0, m_entry};
            m_ovf = m_ovf | (full > 64'hFFFF_FFFF);
            m_saved = full[31:0];
          end
          2: begin
            m_ovf = m_ovf | (m_saved < m_entry);
            m_saved = m_saved - m_entry;
          end
          3: begin
            full = {32'b0, m_saved} * {32'b0, m_entry};
            m_ovf = m_ovf | ((full >> 32) != 0);
            m_saved = full[31:0];
            is_mul = 1;
          end
          default: m_saved = m_entry;
        endcase
      end
      m_ds = 1;
      if (k == K_EQ) m_eq = 1;
      else begin
        m_op = (k == K_ADD) ? 1 : (k == K_SUB) ? 2 : 3;
        m_entry = '0;
        m_eq = 0;
      end
    end
  endtask

  // Driver: waits for key_ready, pulses one key, then waits out any multiply.
  task automatic press(input logic [4:0] k, output int bc, output bit is_mul);
    int w = 0;
    while (key_ready !== 1'b1 && w < 100) begin @(negedge clk); w++; end
    checks++;
    if (key_ready !== 1'b1) begin
      errors++;
      $display("FAIL press_ready_timeout key_ready=%b want 1", key_ready);
    end
    model_key(k, is_mul);
    key = k; key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    bc = 0;
    while (busy === 1'b1 && bc < 100) begin bc++; @(negedge clk); end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    model_clear();
    checks++;
    if ({entry, saved, displaysaved, overflow, busy, key_ready, key_drop} !==
        {32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_values got entry=%h saved=%h ds=%b ovf=%b busy=%b rdy=%b drop=%b",
               entry, saved, displaysaved, overflow, busy, key_ready, key_drop);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add();
    int bc, any_busy = 0; bit im;
    press(5'd1, bc, im); any_busy += bc;
    press(5'd2, bc, im); any_busy += bc;
    checks++;
    if (entry !== 32'h12) begin errors++; $display("FAIL add_entry got %h want 00000012", entry); end
    press(K_ADD, bc, im); any_busy += bc;
    press(5'd3, bc, im); any_busy += bc;
    press(K_EQ, bc, im); any_busy += bc;
    checks++;
    if ({saved, displaysaved} !== {32'h15, 1'b1}) begin
      errors++; $display("FAIL add_eq got saved=%h ds=%b want 00000015 1", saved, displaysaved);
    end
    checks++;
    if (any_busy != 0) begin errors++; $display("FAIL add_busy got %0d busy cycles want 0", any_busy); end
  endtask

  task automatic test_sub();
    int bc; bit im;
    press(K_CLR, bc, im);
    press(5'd5, bc, im); press(K_SUB, bc, im); press(5'd7, bc, im); press(K_EQ, bc, im);
    checks++;
    if ({saved, overflow} !== {32'hFFFF_FFFE, 1'b1}) begin
      errors++; $display("FAIL sub_borrow got saved=%h ovf=%b want fffffffe 1", saved, overflow);
    end
    press(5'd4, bc, im);
    checks++;
    if ({entry, saved, overflow, displaysaved} !== {32'h4, 32'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL sub_digit_after_eq got entry=%h saved=%h ovf=%b ds=%b want 4 0 0 0",
               entry, saved, overflow, displaysaved);
    end
  endtask

  task automatic test_mul_drop();
    int bc, n, bad_ready; bit im;
    press(K_CLR, bc, im);
    press(5'd1, bc, im); press(5'd2, bc, im); press(5'd3, bc, im); press(5'd4, bc, im);
    press(K_MUL, bc, im); press(5'd1, bc, im); press(5'd0, bc, im);
    checks++;
    if ({entry, saved} !== {32'h10, 32'h1234}) begin
      errors++; $display("FAIL mul_setup got entry=%h saved=%h want 10 1234", entry, saved);
    end
    model_key(K_EQ, im);
    key = K_EQ; key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    n = 0; bad_ready = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      if (key_ready !== 1'b0) bad_ready++;
      if (n == 6) begin
        key_valid = 1'b0;
        checks++;
        if ({key_drop, entry, saved} !== {1'b1, 32'h10, 32'h1234}) begin
          errors++;
          $display("FAIL mul_drop got drop=%b entry=%h saved=%h want 1 10 1234", key_drop, entry, saved);
        end
      end
      if (n == 5) begin key = 5'd7; key_valid = 1'b1; end
      @(negedge clk);
    end
    checks++;
    if (n != 32) begin errors++; $display("FAIL mul_busy_len got %0d want 32", n); end
    checks++;
    if (bad_ready != 0) begin errors++; $display("FAIL mul_ready_low got %0d bad cycles want 0", bad_ready); end
    checks++;
    if ({saved, entry, displaysaved, key_ready} !== {32'h12340, m_entry, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL mul_result got saved=%h entry=%h ds=%b rdy=%b want 12340 %h 1 1",
               saved, entry, displaysaved, key_ready, m_entry);
    end
  endtask

  task automatic test_mul_overflow();
    int bc; bit im;
    press(K_CLR, bc, im);
    press(5'd1, bc, im); repeat (4) press(5'd0, bc, im);
    press(K_MUL, bc, im);
    press(5'd1, bc, im); repeat (4) press(5'd0, bc, im);
    press(K_EQ, bc, im);
    checks++;
    if ({saved, overflow} !== {32'h0, 1'b1} || bc != 32) begin
      errors++; $display("FAIL mul_overflow got saved=%h ovf=%b cycles=%0d want 0 1 32", saved, overflow, bc);
    end
  endtask

  task automatic test_digits();
    int bc; bit im;
    press(K_CLR, bc, im);
    for (int d = 1; d <= 8; d++) press(5'(d), bc, im);
    checks++;
    if (entry !== 32'h1234_5678) begin errors++; $display("FAIL digits_fill got %h want 12345678", entry); end
    press(5'd9, bc, im);
    checks++;
    if (entry !== 32'h1234_5678) begin errors++; $display("FAIL digits_full got %h want 12345678", entry); end
    press(K_BKSP, bc, im);
    checks++;
    if (entry !== 32'h0123_4567) begin errors++; $display("FAIL digits_bksp got %h want 01234567", entry); end
  endtask

  task automatic test_reset_mid_mul();
    int bc, stale = 0; bit im;
    press(K_CLR, bc, im);
    press(5'd3, bc, im); press(K_MUL, bc, im); press(5'd5, bc, im);
    key = K_EQ; key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    repeat (9) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL abort_precond busy=%b want 1", busy); end
    #2 reset = 1'b0;
    #1;
    model_clear();
    checks++;
    if ({entry, saved, displaysaved, overflow, busy, key_ready, key_drop} !==
        {32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL abort_reset got entry=%h saved=%h ds=%b ovf=%b busy=%b rdy=%b drop=%b",
               entry, saved, displaysaved, overflow, busy, key_ready, key_drop);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (busy !== 1'b0 || key_ready !== 1'b1 || saved !== 32'h0 || entry !== 32'h0) stale++;
    end
    checks++;
    if (stale != 0) begin errors++; $display("FAIL abort_stale got %0d bad cycles want 0", stale); end
  endtask

  task automatic test_random();
    int bc, r; bit im; logic [4:0] k;
    press(K_CLR, bc, im);
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 99);
      if (r < 55)      k = 5'($urandom_range(0, 15));
      else if (r < 62) k = K_EQ;
      else if (r < 68) k = K_BKSP;
      else if (r < 74) k = K_SUB;
      else if (r < 80) k = K_ADD;
      else if (r < 88) k = K_MUL;
      else if (r < 90) k = K_CLR;
      else             k = 5'($urandom_range(22, 31));
      press(k, bc, im);
      checks++;
      if ({entry, saved, displaysaved, overflow} !== {m_entry, m_saved, m_ds, m_ovf} ||
          bc != (im ? 32 : 0)) begin
        errors++;
        $display("FAIL random_%0d key=%0d got entry=%h saved=%h ds=%b ovf=%b cyc=%0d want %h %h %b %b %0d",
                 i, k, entry, saved, displaysaved, overflow, bc,
                 m_entry, m_saved, m_ds, m_ovf, im ? 32 : 0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_mul_drop();
    test_mul_overflow();
    test_digits();
    test_reset_mid_mul();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/calc_ctrl.md
# calc_ctrl

Key-driven sequencing controller for the hex calculator datapath. It consumes one-cycle key events from the keypad scanner, owns the `entry`, `saved`, pending-operation and display-select registers, and sequences the arithmetic unit. Add and subtract complete in one cycle; multiply uses a 32-step shift-add. It sits between the key scanner and the seven-segment decoders, replacing the ad-hoc key-edge-clocked logic with a single-clock FSM plus a ready/busy handshake.

## Interface
- `WIDTH`, 32, operand/result width; must be a multiple of 4.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted when 0).
- `key_valid`  in  1  one-cycle key event strobe.
- `key`  in  5  key code, sampled when `key_valid`.
- `key_ready`  out  1  high when a key will be accepted this cycle.
- `key_drop`  out  1  one-cycle pulse when `key_valid` arrives while `key_ready`=0.
- `entry`  out  WIDTH  operand being typed.
- `saved`  out  WIDTH  accumulated result.
- `displaysaved`  out  1  1 = display `saved`, 0 = display `entry`.
- `busy`  out  1  multiply in progress.
- `overflow`  out  1  sticky arithmetic overflow flag.

## Operation
- Key codes: 0–15 digit; 16 EQ; 17 BKSP; 18 SUB; 19 ADD; 20 MUL; 21 CLR; 22–31 ignored (accepted, no effect).
- Internal regs: `op` (NONE/ADD/SUB/MUL), `eqflag`.
- apply(op): NONE→entry; ADD→saved+entry; SUB→saved−entry; MUL→low WIDTH bits of saved×entry. All results are modulo 2^WIDTH.
- Digit: if `eqflag`: entry=digit, saved=0, op=NONE, displaysaved=0, eqflag=0, overflow=0. Else if entry[WIDTH-1:WIDTH-4]==0: entry=(entry<<4)|digit; otherwise the digit is discarded. In both non-eqflag cases, displaysaved=0.
- BKSP: if displaysaved==0, entry=entry>>4; else no effect.
- EQ: saved=apply(op), displaysaved=1, eqflag=1; op and entry unchanged.
- ADD/SUB/MUL: if eqflag==0, saved=apply(op). Then op=key, entry=0, displaysaved=1, eqflag=0.
- CLR: all registers return to reset values.
- Overflow is set by an ADD carry-out, a SUB borrow, or a nonzero MUL high half. It is cleared only by reset, CLR, or a digit entered after EQ.
- FSM: IDLE, MUL.
  - IDLE→MUL when an accepted key needs apply() and op==MUL.
  - MUL→IDLE after WIDTH iterations, then the deferred key's commit.
  - All other keys complete in IDLE.

## Timing
- Reset values: entry=0, saved=0, op=NONE, displaysaved=0, eqflag=0, overflow=0, busy=0, key_drop=0, key_ready=1, state IDLE.
- A key is accepted at edge k when key_valid && key_ready.
- Non-MUL: all register updates are visible after edge k. key_ready stays 1, so back-to-back keys are legal every cycle.
- MUL:
  - At edge k: busy=1, key_ready=0. Operands are latched; entry/saved still show their old values.
  - One multiplier bit is processed per cycle.
  - At edge k+WIDTH: the whole key commit happens, busy=0, key_ready=1.
- key_valid while busy: key is discarded, key_drop pulses the following cycle, no state change.
- Reset asserted mid-multiply: immediate abort to reset values; no partial commit.
- key_ready is combinational from state only (not from key_valid).

## Structure
- Package `calc_pkg`: key-code constants, `op_t` enum (NONE/ADD/SUB/MUL), `state_t` enum (IDLE/MUL).
- Sub-module `mul_shiftadd`:
  - Inputs: start, a, b.
  - Outputs: done, product low half, high-nonzero flag.
  - Iterative, WIDTH cycles, same clock/reset.
- Key decode, register file and FSM live in `calc_ctrl`.

## Test plan
- Reset → entry=0, saved=0, displaysaved=0, overflow=0, busy=0, key_ready=1.
- Keys 1,2,ADD,3,EQ → entry=0x12 after the second digit; after EQ saved=0x15, displaysaved=1, busy never asserted.
- Keys 5,SUB,7,EQ → saved=0xFFFFFFFE, overflow=1. Then digit 4 → entry=4, saved=0, overflow=0, displaysaved=0.
- Keys 1,2,3,4,MUL,1,0,EQ:
  - busy=1 and key_ready=0 for exactly 32 cycles.
  - A key pulsed at cycle 5 gives key_drop=1 and no state change.
  - Final saved=0x12340.
- Multiply 0x10000×0x10000 → saved=0, overflow=1.
- Digits 1..8 → entry=0x12345678. Digit 9 → unchanged. BKSP → 0x01234567.
- Reset asserted at cycle 10 of a multiply → all outputs at reset values immediately. After release, key_ready=1 and no stale commit occurs.
